// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle: single-beat address/data channels with valid/ready.
// clk/rst_n travel with the bus for slaves; the command master runs from its own clock and reset.
interface axi4_lite_if (
   input logic clk,
   input logic rst_n
);
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  clk, rst_n,
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master turning cmd requests into rsp completions; 3 cycles min latency.
// cmd_ready only in IDLE; a held-off rsp_ready parks the FSM in RSP with completion fields frozen.
module axi4_lite_cmd_master #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [31:0]      cmd_addr,
   input  logic [31:0]      cmd_wdata,
   input  logic [3:0]       cmd_wstrb,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_write,
   output logic [31:0]      rsp_rdata,
   output logic [1:0]       rsp_resp,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] err_count,
   axi4_lite_if.master      axi_bus
);
   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        arvalid_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        cmd_hs;
   logic        aw_hs;
   logic        w_hs;
   logic        b_hs;
   logic        ar_hs;
   logic        r_hs;
   logic        rsp_hs;

   assign cmd_ready = (state == IDLE) && !rst;
   assign rsp_valid = (state == RSP);
   assign cmd_hs    = cmd_valid && cmd_ready;
   assign aw_hs     = awvalid_q && axi_bus.awready;
   assign w_hs      = wvalid_q && axi_bus.wready;
   assign b_hs      = axi_bus.bvalid && axi_bus.bready;
   assign ar_hs     = arvalid_q && axi_bus.arready;
   assign r_hs      = axi_bus.rvalid && axi_bus.rready;
   assign rsp_hs    = rsp_valid && rsp_ready;

   assign axi_bus.awvalid = awvalid_q;
   assign axi_bus.awaddr  = addr_q;
   assign axi_bus.wvalid  = wvalid_q;
   assign axi_bus.wdata   = wdata_q;
   assign axi_bus.wstrb   = wstrb_q;
   assign axi_bus.bready  = (state == WR_B);
   assign axi_bus.arvalid = arvalid_q;
   assign axi_bus.araddr  = addr_q;
   assign axi_bus.rready  = (state == RD_R);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR_AW_W : RD_AR;
         // A channel counts as done once its valid has dropped or it handshakes this cycle.
         WR_AW_W: if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) state_nxt = WR_B;
         WR_B:    if (b_hs) state_nxt = RSP;
         RD_AR:   if (ar_hs) state_nxt = RD_R;
         RD_R:    if (r_hs) state_nxt = RSP;
         RSP:     if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= '0;
         wr_count  <= '0;
         rd_count  <= '0;
         err_count <= '0;
      end else begin
         if (cmd_hs) begin
            addr_q <= cmd_addr;
            if (cmd_write) begin
               wdata_q   <= cmd_wdata;
               wstrb_q   <= cmd_wstrb;
               awvalid_q <= 1'b1;
               wvalid_q  <= 1'b1;
            end else begin
               arvalid_q <= 1'b1;
            end
         end
         if (aw_hs) awvalid_q <= 1'b0;
         if (w_hs)  wvalid_q  <= 1'b0;
         if (ar_hs) arvalid_q <= 1'b0;
         if (b_hs) begin
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= axi_bus.bresp;
         end
         if (r_hs) begin
            rsp_write <= 1'b0;
            rsp_rdata <= axi_bus.rdata;
            rsp_resp  <= axi_bus.rresp;
         end
         // Statistics move only when the requester actually takes the completion.
         if (rsp_hs) begin
            if (rsp_write) wr_count <= wr_count + 1'b1;
            else           rd_count <= rd_count + 1'b1;
            if (rsp_resp != 2'b00) err_count <= err_count + 1'b1;
         end
      end
   end
endmodule

// File: doc/axi4_lite_cmd_master.md
AXI4_LITE_CMD_MASTER -- requirements
Module: axi4_lite_cmd_master

Interface
REQ-001 Parameter CNT_W, default 16: width of the transaction/error statistics counters.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  32  byte address.
REQ-009 cmd_wdata  input  32  write data; ignored for reads.
REQ-010 cmd_wstrb  input  4  write strobes; ignored for reads.
REQ-011 rsp_valid  output  1  completion available.
REQ-012 rsp_ready  input  1  completion consumed when high with rsp_valid.
REQ-013 rsp_write  output  1  echo of cmd_write for this completion.
REQ-014 rsp_rdata  output  32  read data; 0 for writes.
REQ-015 rsp_resp  output  2  bresp or rresp returned by the slave.
REQ-016 wr_count, rd_count, err_count  output  CNT_W  completed writes, completed reads, completions with resp != 2'b00.
REQ-017 axi_bus  interface  axi4_lite_if.master  AXI4-Lite bus; clk/rst_n inside the interface are not used by this block.

Function
REQ-018 FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP; only one transaction is outstanding at a time.
REQ-019 cmd_ready = 1 only in IDLE with rst low; it is combinational from state.
REQ-020 IDLE, cmd_valid && cmd_write: latch addr/wdata/wstrb, next cycle awvalid = wvalid = 1, go to WR_AW_W.
REQ-021 IDLE, cmd_valid && !cmd_write: latch addr, next cycle arvalid = 1, go to RD_AR.
REQ-022 WR_AW_W: AW and W complete independently; awvalid drops the cycle after awvalid && awready, and wvalid drops the cycle after wvalid && wready; awaddr/wdata/wstrb stay stable while their valid is high.
REQ-023 AW and W handshakes in the same cycle, or in either order, are legal; go to WR_B in the cycle after both have completed.
REQ-024 WR_B: bready = 1; on bvalid && bready, capture bresp into rsp_resp, set rsp_write = 1 and rsp_rdata = 0, go to RSP.
REQ-025 RD_AR: hold arvalid/araddr until arvalid && arready, drop arvalid the next cycle, go to RD_R; rready = 1 from RD_R entry.
REQ-026 If rvalid is already high in the cycle the AR handshake completes, it is captured in RD_R on the next edge; no R beat is dropped.
REQ-027 RD_R: on rvalid && rready, capture rdata/rresp, set rsp_write = 0, go to RSP.
REQ-028 bready and rready are high only in WR_B and RD_R respectively.
REQ-029 RSP: rsp_valid = 1 and its fields held stable; on rsp_ready return to IDLE.
REQ-030 Completion is counted in the cycle of rsp_valid && rsp_ready: wr_count or rd_count increments, and err_count also increments if rsp_resp != 0.
REQ-031 All counters wrap modulo 2^CNT_W.
REQ-032 A new command can be accepted no earlier than the cycle after the RSP handshake.
REQ-033 Minimum latency, cmd accept to rsp_valid, against a zero-wait slave: 3 cycles for reads and 3 cycles for writes.
REQ-034 No timeout: a silent slave stalls the FSM indefinitely.

Reset
REQ-035 rst high forces immediately: state IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid all 0; addresses/data/strb/rsp fields 0; all counters 0.
REQ-036 Reset mid-transaction abandons the transaction without a completion or counter update.
REQ-037 After reset deasserts, the first edge is IDLE with cmd_ready = 1.

Verification
REQ-038 Write 0x12345678 to 0x4, wstrb 0xF, to memory slave -> rsp_resp 00, rsp_write 1, wr_count 1; slave register 1 = 0x12345678.
REQ-039 Read 0x4 after the write above -> rsp_rdata 0x12345678, rsp_resp 00, rd_count 1.
REQ-040 Write to 0x100 -> rsp_resp 10, err_count 1; then read 0x100 -> rsp_rdata 0xDEADC0DE, rsp_resp 10, err_count 2.
REQ-041 Slave model with wready 3 cycles before awready, then with awready first -> both complete with one B handshake; awvalid/wvalid each drop one cycle after their own handshake.
REQ-042 Hold rsp_ready low for 5 cycles -> rsp_valid and its fields stable, cmd_ready 0; a pending cmd_valid is accepted only after the RSP handshake.
REQ-043 Assert rst during WR_B -> all valids 0 in the same cycle, counters 0; a subsequent read of 0x0 completes normally.
